// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a req/rdy handshake with
// programmable wait states and an error response for bad accesses.
module dmem_responder #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_w_data,
  input  logic        mem_we,
  input  logic        mem_oe,
  output logic [31:0] mem_r_data,
  output logic        mem_rdy,
  output logic        mem_err,
  output logic        busy
);
  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
    logic              we;
    logic              oe;
    logic              err;
  } req_t;

  state_t      state;
  req_t        req;
  logic [3:0]  cnt;
  logic        req_vld;
  logic        acc_err;
  logic [31:0] ram [2**ADDR_W];

  assign req_vld = mem_we | mem_oe;
  // BASE_ADDR is window-aligned, so the range test is a compare of the upper
  // bits and the word index is simply the address bits above the byte offset.
  assign acc_err = (mem_addr[1:0] != 2'b00)
                 || (mem_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
                 || (mem_we && mem_oe);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      mem_rdy    <= 1'b0;
      mem_err    <= 1'b0;
      mem_r_data <= '0;
      busy       <= 1'b0;
    end else begin
      mem_rdy <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the rdy cycle and drops on the edge after it
          busy <= req_vld;
          if (req_vld) begin
            req <= '{idx: mem_addr[ADDR_W+1:2], data: mem_w_data,
                     we: mem_we, oe: mem_oe, err: acc_err};
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              cnt   <= WAIT_LD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          mem_rdy    <= 1'b1;
          mem_err    <= req.err;
          mem_r_data <= (req.oe && !req.err) ? ram[req.idx] : '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive rst, and an aborted access never
  // reaches RESP so its write is dropped.
  always_ff @(posedge clk) begin
    if (state == RESP && req.we && !req.err) ram[req.idx] <= req.data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: dut 0 runs WAIT_CYCLES=1, dut 1 runs WAIT_CYCLES=0.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic        we_s   [2];
  logic        oe_s   [2];
  logic [31:0] rd_s   [2];
  logic        rdy_s  [2];
  logic        err_s  [2];
  logic        busy_s [2];

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr_s[0]), .mem_w_data(wd_s[0]),
    .mem_we(we_s[0]), .mem_oe(oe_s[0]), .mem_r_data(rd_s[0]),
    .mem_rdy(rdy_s[0]), .mem_err(err_s[0]), .busy(busy_s[0]));

  dmem_responder #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr_s[1]), .mem_w_data(wd_s[1]),
    .mem_we(we_s[1]), .mem_oe(oe_s[1]), .mem_r_data(rd_s[1]),
    .mem_rdy(rdy_s[1]), .mem_err(err_s[1]), .busy(busy_s[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rdy dut%0d: got pulse expected none at %0t", d, $time);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("rsp_err dut%0d", d), 32'(err_s[d]), 32'(e.err));
      chk($sformatf("rsp_rdata dut%0d", d), rd_s[d], e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (rdy_s[0]) mon(0);
    if (rdy_s[1]) mon(1);
  end

  // One access; reps>1 holds the request through mem_rdy to get repeats.
  // chg swaps addr/data in the cycle after acceptance.
  task automatic access(input int d, input logic we, input logic oe,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd,
                        input int reps, input bit chg,
                        input logic [31:0] alt_a, input logic [31:0] alt_d);
    exp_t e;
    int   wcy;
    int   lat;
    int   bcnt;
    bit   got;
    wcy = (d == 0) ? 1 : 0;
    e.err = e_err;
    e.rd  = e_rd;
    for (int r = 0; r < reps; r++) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    addr_s[d] = a; wd_s[d] = wd; we_s[d] = we; oe_s[d] = oe;
    for (int r = 0; r < reps; r++) begin
      lat = 0; bcnt = 0; got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (busy_s[d]) bcnt++;
        if (chg && lat == 1) begin
          addr_s[d] = alt_a; wd_s[d] = alt_d;
        end
        if (rdy_s[d]) got = 1'b1;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL rdy_timeout dut%0d addr 0x%08h: got no rdy expected rdy", d, a);
      end else begin
        chk($sformatf("latency dut%0d addr 0x%08h", d, a), 32'(lat), 32'(wcy + 2));
      end
      if (r == reps - 1) begin
        we_s[d] = 1'b0; oe_s[d] = 1'b0;
      end
    end
    if (reps == 1) chk($sformatf("busy_cycles dut%0d", d), 32'(bcnt), 32'(wcy + 2));
    @(negedge clk);
    chk($sformatf("busy_after dut%0d", d), 32'(busy_s[d]), 32'd0);
    chk($sformatf("rdata_hold dut%0d", d), rd_s[d], e_rd);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v, input logic e_err);
    access(d, 1'b1, 1'b0, a, v, e_err, 32'h0, 1, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rdd(input int d, input logic [31:0] a, input logic e_err, input logic [31:0] v);
    access(d, 1'b0, 1'b1, a, 32'h0, e_err, v, 1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr_s[d] = '0; wd_s[d] = '0; we_s[d] = 1'b0; oe_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdy dut%0d", d),  32'(rdy_s[d]),  32'd0);
      chk($sformatf("reset_err dut%0d", d),  32'(err_s[d]),  32'd0);
      chk($sformatf("reset_busy dut%0d", d), 32'(busy_s[d]), 32'd0);
      chk($sformatf("reset_rdata dut%0d", d), rd_s[d], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);

    // basic write/read, plus a known value at 0x10
    wr(0, 32'h10, 32'hCAFE_0010, 1'b0);
    wr(0, 32'h40, 32'h1234_5678, 1'b0);
    rdd(0, 32'h40, 1'b0, 32'h1234_5678);

    // reset during WAIT of a write to 0x10 aborts it
    @(negedge clk);
    addr_s[0] = 32'h10; wd_s[0] = 32'hDEAD_BEEF; we_s[0] = 1'b1;
    @(negedge clk);
    chk("busy_in_wait", 32'(busy_s[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    we_s[0] = 1'b0;
    chk("busy_abort", 32'(busy_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rdd(0, 32'h10, 1'b0, 32'hCAFE_0010);

    // error responses
    rdd(0, 32'h42, 1'b1, 32'h0);
    wr(0, 32'hFFC, 32'hA5A5_A5A5, 1'b0);
    wr(0, 32'h1000, 32'h1111_1111, 1'b1);
    rdd(0, 32'hFFC, 1'b0, 32'hA5A5_A5A5);
    access(0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 1'b0, 32'h0, 32'h0);
    rdd(0, 32'h40, 1'b0, 32'h1234_5678);

    // held request is accepted twice; dropped request once
    access(0, 1'b1, 1'b0, 32'h80, 32'h0BAD_F00D, 1'b0, 32'h0, 2, 1'b0, 32'h0, 32'h0);
    rdd(0, 32'h80, 1'b0, 32'h0BAD_F00D);

    // inputs changing while busy are ignored
    wr(0, 32'h84, 32'h8484_8484, 1'b0);
    access(0, 1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 32'h0BAD_F00D, 1, 1'b1, 32'h84, 32'h0);
    access(0, 1'b1, 1'b0, 32'h80, 32'h7777_7777, 1'b0, 32'h0, 1, 1'b1, 32'h84, 32'h9999_9999);
    rdd(0, 32'h84, 1'b0, 32'h8484_8484);
    rdd(0, 32'h80, 1'b0, 32'h7777_7777);

    // zero-wait instance
    wr(1, 32'h20, 32'h55AA_55AA, 1'b0);
    rdd(1, 32'h20, 1'b0, 32'h55AA_55AA);
    rdd(1, 32'h42, 1'b1, 32'h0);
    access(1, 1'b1, 1'b0, 32'h24, 32'h0000_0024, 1'b0, 32'h0, 2, 1'b0, 32'h0, 32'h0);
    rdd(1, 32'h24, 1'b0, 32'h0000_0024);

    repeat (4) @(negedge clk);
    chk("pending_dut0", 32'(q0.size()), 32'd0);
    chk("pending_dut1", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave) end of the core's data port: accepts word read/write requests driven by the core's mem-access stage and returns read data with a ready handshake.
- Owns a word-addressed on-chip RAM with programmable wait states and an error flag for misaligned or out-of-range accesses.
- Its ready output feeds the pipeline stall logic.
- Sits between the core and the data SRAM.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W.
- WAIT_CYCLES, 1, extra cycles inserted before a response, range 0..15.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- mem_addr  input  32  byte address of the request (core d_mem_w_addr)
- mem_w_data  input  32  write data
- mem_we  input  1  write request
- mem_oe  input  1  read request
- mem_r_data  output  32  read data, valid while mem_rdy=1 for a read
- mem_rdy  output  1  one-cycle response pulse ending an access
- mem_err  output  1  qualifies mem_rdy; 1 means the access was rejected
- busy  output  1  high from acceptance until the cycle after mem_rdy

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; mem_rdy=0, mem_err=0, busy=0, mem_r_data=0, wait counter=0.
  - RAM contents are not reset and are preserved across reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - A request exists when mem_we|mem_oe=1. On that edge, latch addr, data, we and oe, and set busy=1.
  - If WAIT_CYCLES=0, go to RESP; else load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; when counter=0, go to RESP.
- RESP:
  - Assert mem_rdy=1 for exactly one cycle. Drive mem_err and, for a good read, mem_r_data from the RAM at the latched word.
  - A good write commits the latched data to RAM on the RESP edge.
  - Next state is IDLE, with busy=0 after that edge.
- Latency: a request accepted at edge N produces mem_rdy=1 in the cycle after edge N+WAIT_CYCLES+1. The minimum is 2 cycles at WAIT_CYCLES=0.
- Requester rules:
  - The requester holds addr, data, we and oe stable until it sees mem_rdy.
  - Inputs are ignored while not in IDLE; only the latched copy is used.
  - If the request is still asserted in the first IDLE cycle after RESP, it is accepted as a new access. The requester drops we/oe in the mem_rdy cycle to avoid this.
- Error conditions, each gives mem_rdy=1 with mem_err=1, no RAM write, and mem_r_data=0:
  - mem_addr[1:0] != 0.
  - mem_addr outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W - 1].
  - mem_we=1 and mem_oe=1 together.
- Word index = (mem_addr - BASE_ADDR) >> 2, truncated to ADDR_W bits; no wrap-around is possible because out-of-range is rejected.
- mem_r_data:
  - Holds its last value outside mem_rdy cycles.
  - Is 0 after a write response or an error response.
- Read-after-write to the same address in back-to-back accesses returns the new data (the write commits before the next acceptance).
- Reset mid-access (during WAIT or RESP):
  - The access is aborted and no mem_rdy is produced.
  - A pending write that has not reached the RESP edge is discarded.

Test Plan:
- Reset: drive rst=0 mid-WAIT with mem_we=1, addr 0x10, data 0xDEADBEEF -> mem_rdy never pulses; a later read of 0x10 returns the prior contents, not 0xDEADBEEF.
- Basic write then read (WAIT_CYCLES=1):
  - Write 0x0000_0040 <- 0x1234_5678, accepted at edge 0 -> mem_rdy=1, mem_err=0 in the cycle after edge 2.
  - Read 0x40 -> mem_r_data=0x1234_5678 with mem_rdy.
- Zero wait (WAIT_CYCLES=0): read accepted at edge N -> mem_rdy in the cycle after edge N+1; busy high for exactly 2 cycles.
- Errors:
  - Read 0x42 -> mem_err=1, mem_r_data=0.
  - Write to BASE_ADDR+4*2**ADDR_W -> mem_err=1; the last word (addr 0xFFC) is unchanged.
  - we=oe=1 -> mem_err=1.
- Back-to-back: hold the write request through mem_rdy -> a second identical write is accepted in the following IDLE cycle and a second mem_rdy pulse occurs; dropping we in the mem_rdy cycle yields exactly one pulse.
- Input change while busy: change addr from 0x80 to 0x84 during WAIT -> the response uses 0x80 data; 0x84 is untouched.
